// File: rtl/upstream_req_arbiter_if.sv
// Requester/cache handshake bundle for the upstream request arbiter.
// slave = arbiter side, master = requesters plus cache FSM side.
interface upstream_req_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_rw;
    logic [NREQ*32-1:0] req_addr;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]    resp_valid;
    logic [31:0]        resp_data;
    logic               resp_err;
    logic               cpu_req_valid;
    logic               cpu_req_rw;
    logic [31:0]        cpu_req_addr;
    logic [31:0]        cpu_req_data;
    logic               cpu_res_ready;
    logic [31:0]        cpu_res_data;
    logic               timeout_flag;

    modport slave (
        input  req_valid, req_rw, req_addr, req_data,
        input  cpu_res_ready, cpu_res_data,
        output req_ready, resp_valid, resp_data, resp_err,
        output cpu_req_valid, cpu_req_rw, cpu_req_addr, cpu_req_data,
        output timeout_flag
    );

    modport master (
        output req_valid, req_rw, req_addr, req_data,
        output cpu_res_ready, cpu_res_data,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  cpu_req_valid, cpu_req_rw, cpu_req_addr, cpu_req_data,
        input  timeout_flag
    );
endinterface

// File: rtl/upstream_req_arbiter.sv
// Round-robin arbiter funnelling order-entry requests into one cache FSM,
// one transaction at a time, with a per-transaction timeout.
module upstream_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    upstream_req_arbiter_if.slave bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] last_q, last_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          cpu_valid_q, cpu_valid_d;
    logic          cpu_rw_q, cpu_rw_d;
    logic [31:0]   cpu_addr_q, cpu_addr_d;
    logic [31:0]   cpu_data_q, cpu_data_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          tflag_q, tflag_d;

    logic [GW-1:0]   win;
    logic            any;
    logic [NREQ-1:0] ready_c;
    logic [NREQ-1:0] rvalid_c;
    logic [8:0]      cnt_inc;
    logic            hit;

    // Search starts one past the last grant and wraps.
    always_comb begin
        win = '0;
        any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last_q) + k) % NREQ;
            if (!any && bus.req_valid[idx]) begin
                any = 1'b1;
                win = GW'(idx);
            end
        end
    end

    assign cnt_inc = {1'b0, cnt_q} + 9'd1;
    assign hit     = (cnt_inc == 9'(TIMEOUT));

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        cpu_valid_d = cpu_valid_q;
        cpu_rw_d   = cpu_rw_q;
        cpu_addr_d = cpu_addr_q;
        cpu_data_d = cpu_data_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        tflag_d    = tflag_q;
        ready_c    = '0;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    ready_c[win] = 1'b1;
                    last_d       = win;
                    grant_d      = win;
                    cnt_d        = '0;
                    cpu_valid_d  = 1'b1;
                    cpu_rw_d     = bus.req_rw[win];
                    cpu_addr_d   = bus.req_addr[32*win +: 32];
                    cpu_data_d   = bus.req_data[32*win +: 32];
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // A late cache answer still beats the timeout.
                if (bus.cpu_res_ready) begin
                    rdata_d     = bus.cpu_res_data;
                    err_d       = 1'b0;
                    cpu_valid_d = 1'b0;
                    state_d     = RESP;
                end else if (hit) begin
                    rdata_d     = '0;
                    err_d       = 1'b1;
                    tflag_d     = 1'b1;
                    cpu_valid_d = 1'b0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_inc[7:0];
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rvalid_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            rvalid_c[i] = (state_q == RESP) && (grant_q == GW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= GW'(NREQ - 1);
            grant_q     <= '0;
            cnt_q       <= '0;
            cpu_valid_q <= 1'b0;
            cpu_rw_q    <= 1'b0;
            cpu_addr_q  <= '0;
            cpu_data_q  <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            tflag_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            cpu_valid_q <= cpu_valid_d;
            cpu_rw_q    <= cpu_rw_d;
            cpu_addr_q  <= cpu_addr_d;
            cpu_data_q  <= cpu_data_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            tflag_q     <= tflag_d;
        end
    end

    assign bus.req_ready     = ready_c;
    assign bus.resp_valid    = rvalid_c;
    assign bus.resp_data     = rdata_q;
    assign bus.resp_err      = err_q;
    assign bus.cpu_req_valid = cpu_valid_q;
    assign bus.cpu_req_rw    = cpu_rw_q;
    assign bus.cpu_req_addr  = cpu_addr_q;
    assign bus.cpu_req_data  = cpu_data_q;
    assign bus.timeout_flag  = tflag_q;
endmodule

// File: tb/tb_upstream_req_arbiter.sv
// Bench for upstream_req_arbiter: transaction-level model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_upstream_req_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    upstream_req_arbiter_if #(.NREQ(NREQ)) bus ();

    upstream_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Cache responder: ready on the lat-th cycle of a request (0 = never).
    int          cache_lat    = 2;
    bit          cache_always = 1'b0;
    logic [31:0] cache_word   = '0;
    int          issue_seen   = 0;

    always @(posedge clk) begin
        #1;
        if (bus.cpu_req_valid) issue_seen++;
        else issue_seen = 0;
        bus.cpu_res_ready = cache_always ||
            (cache_lat != 0 && issue_seen == cache_lat);
        bus.cpu_res_data = cache_word;
    end

    // Model: phase 0 free, 1 waiting on cache, 2 answering requester.
    int          m_phase, m_ptr, m_owner, m_wait, w;
    logic        m_rw, m_err, m_flag;
    logic [31:0] m_addr, m_data, m_rdata;
    bit          started = 1'b0;

    function automatic int pick(input logic [NREQ-1:0] v, input int start);
        for (int k = 0; k < NREQ; k++)
            if (v[(start + k) % NREQ]) return (start + k) % NREQ;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_owner = 0; m_wait = 0;
            m_rw = 0; m_addr = 0; m_data = 0;
            m_rdata = 0; m_err = 0; m_flag = 0;
        end else if (m_phase == 0) begin
            w = pick(bus.req_valid, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_ptr   = (w + 1) % NREQ;
                m_rw    = bus.req_rw[w];
                m_addr  = bus.req_addr[32*w +: 32];
                m_data  = bus.req_data[32*w +: 32];
                m_wait  = 0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_wait++;
            if (bus.cpu_res_ready) begin
                m_rdata = bus.cpu_res_data; m_err = 0; m_phase = 2;
            end else if (m_wait == TIMEOUT) begin
                m_rdata = 0; m_err = 1; m_flag = 1; m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            logic [NREQ-1:0] e_rdy, e_rv;
            int w2;
            e_rdy = '0;
            e_rv  = '0;
            if (m_phase == 0) begin
                w2 = pick(bus.req_valid, m_ptr);
                if (w2 >= 0) e_rdy[w2] = 1'b1;
            end
            if (m_phase == 2) e_rv[m_owner] = 1'b1;
            chk("req_ready", 64'(bus.req_ready), 64'(e_rdy));
            chk("resp_valid", 64'(bus.resp_valid), 64'(e_rv));
            chk("resp_data", 64'(bus.resp_data), 64'(m_rdata));
            chk("resp_err", 64'(bus.resp_err), 64'(m_err));
            chk("cpu_req_valid", 64'(bus.cpu_req_valid), 64'(m_phase == 1));
            chk("cpu_req_rw", 64'(bus.cpu_req_rw), 64'(m_rw));
            chk("cpu_req_addr", 64'(bus.cpu_req_addr), 64'(m_addr));
            chk("cpu_req_data", 64'(bus.cpu_req_data), 64'(m_data));
            chk("timeout_flag", 64'(bus.timeout_flag), 64'(m_flag));
        end
    end

    task automatic run_one(input int idx, input logic rw,
                           input logic [31:0] a, input logic [31:0] d,
                           input int lat, input logic [31:0] word,
                           output int icyc, output logic [3:0] pv,
                           output logic perr, output logic [31:0] pdata,
                           output logic pcpu, output logic [31:0] caddr,
                           output logic crw);
        int n;
        cache_lat  = lat;
        cache_word = word;
        bus.req_rw[idx] = rw;
        bus.req_addr[32*idx +: 32] = a;
        bus.req_data[32*idx +: 32] = d;
        bus.req_valid = 4'b0001 << idx;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready[idx] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("grant_wait_expired", 64'(n), 64'(0));
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        icyc = 0; caddr = '0; crw = 1'b0; n = 0;
        @(negedge clk);
        while (bus.resp_valid == '0 && n < 600) begin
            if (bus.cpu_req_valid) begin
                if (icyc == 0) begin
                    caddr = bus.cpu_req_addr;
                    crw   = bus.cpu_req_rw;
                end
                icyc++;
            end
            n++;
            @(negedge clk);
        end
        if (n >= 600) chk("resp_wait_expired", 64'(n), 64'(0));
        pv    = bus.resp_valid;
        perr  = bus.resp_err;
        pdata = bus.resp_data;
        pcpu  = bus.cpu_req_valid;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          icyc, n, pulses;
        logic [3:0]  pv;
        logic        perr, pcpu, crw;
        logic [31:0] pdata, caddr;
        logic [3:0]  ord [5];
        logic [3:0]  seen [$];

        bus.req_valid = '0;
        bus.req_rw    = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.cpu_res_ready = 1'b0;
        bus.cpu_res_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        chk("rst_cpu_valid", 64'(bus.cpu_req_valid), 64'(0));
        chk("rst_resp_data", 64'(bus.resp_data), 64'(0));
        chk("rst_tflag", 64'(bus.timeout_flag), 64'(0));

        // Round robin with everyone asking.
        ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        cache_lat  = 2;
        cache_word = 32'hA5A5_0001;
        @(posedge clk);
        #1;
        bus.req_valid = 4'b1111;
        n = 0;
        while (seen.size() < 5 && n < 100) begin
            @(negedge clk);
            if (bus.resp_valid != '0) seen.push_back(bus.resp_valid);
            n++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        chk("rr_pulse_count", 64'(seen.size()), 64'(5));
        for (int i = 0; i < 5 && i < seen.size(); i++)
            chk($sformatf("rr_order_%0d", i), 64'(seen[i]), 64'(ord[i]));
        repeat (2) @(posedge clk);
        #1;

        // Write from requester 2, cache answers on third issue cycle.
        run_one(2, 1'b1, 32'h0000_0050, 32'h0100_0005, 3, 32'h0,
                icyc, pv, perr, pdata, pcpu, caddr, crw);
        chk("wr_issue_cycles", 64'(icyc), 64'(3));
        chk("wr_cpu_addr", 64'(caddr), 64'(32'h50));
        chk("wr_cpu_rw", 64'(crw), 64'(1));
        chk("wr_resp_valid", 64'(pv), 64'(4'b0100));
        chk("wr_resp_err", 64'(perr), 64'(0));

        // Read from requester 1.
        run_one(1, 1'b0, 32'h0000_0120, 32'h0, 4, 32'h00FF_0010,
                icyc, pv, perr, pdata, pcpu, caddr, crw);
        chk("rd_resp_data", 64'(pdata), 64'(32'h00FF_0010));
        chk("rd_cpu_valid_low", 64'(pcpu), 64'(0));
        chk("rd_resp_valid", 64'(pv), 64'(4'b0010));

        // Cache ready exactly on the last allowed cycle.
        run_one(2, 1'b0, 32'h0000_0230, 32'h0, TIMEOUT, 32'h1234_5678,
                icyc, pv, perr, pdata, pcpu, caddr, crw);
        chk("edge_issue_cycles", 64'(icyc), 64'(TIMEOUT));
        chk("edge_resp_err", 64'(perr), 64'(0));
        chk("edge_resp_data", 64'(pdata), 64'(32'h1234_5678));
        chk("edge_tflag", 64'(bus.timeout_flag), 64'(0));

        // Cache never answers.
        run_one(3, 1'b0, 32'h0000_0340, 32'h0, 0, 32'hDEAD_BEEF,
                icyc, pv, perr, pdata, pcpu, caddr, crw);
        chk("to_issue_cycles", 64'(icyc), 64'(TIMEOUT));
        chk("to_resp_valid", 64'(pv), 64'(4'b1000));
        chk("to_resp_err", 64'(perr), 64'(1));
        chk("to_resp_data", 64'(pdata), 64'(0));
        chk("to_tflag", 64'(bus.timeout_flag), 64'(1));

        run_one(0, 1'b1, 32'h0000_0010, 32'h7, 1, 32'h0000_0042,
                icyc, pv, perr, pdata, pcpu, caddr, crw);
        chk("post_to_err", 64'(perr), 64'(0));
        chk("post_to_tflag", 64'(bus.timeout_flag), 64'(1));

        // Cache ready all the time, including while idle.
        cache_always = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run_one(3, 1'b0, 32'h0000_0400, 32'h0, 0, 32'h0BAD_F00D,
                icyc, pv, perr, pdata, pcpu, caddr, crw);
        chk("always_issue_cycles", 64'(icyc), 64'(1));
        chk("always_resp_data", 64'(pdata), 64'(32'h0BAD_F00D));
        cache_always = 1'b0;

        // Reset in the middle of an issue.
        cache_lat = 0;
        bus.req_valid = 4'b0010;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready[1] && n < 50) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_cpu_valid", 64'(bus.cpu_req_valid), 64'(0));
        chk("abort_resp_valid", 64'(bus.resp_valid), 64'(0));
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.resp_valid != '0) pulses++;
        end
        chk("abort_no_pulse", 64'(pulses), 64'(0));
        cache_lat = 1;
        @(posedge clk);
        #1;
        bus.req_valid = 4'b1111;
        @(negedge clk);
        chk("abort_next_grant", 64'(bus.req_ready), 64'(4'b0001));
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        repeat (6) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
